// File: rtl/bf16_mult_arbiter.sv
// Four-way round-robin front end that time-shares one bf16 multiplier.
// Defining BF16_ARB_TIMEOUT_EN adds a WAIT-state watchdog that answers qNaN and pulses err_timeout.
module bf16_mult_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [3:0]  req_stb,
    output logic [3:0]  req_busy,
    output logic [15:0] resp_data,
    output logic [3:0]  resp_stb,
    input  logic [3:0]  resp_busy,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_stb,
    input  logic        mul_busy,
    output logic        mul_rst,
    input  logic [15:0] mul_z,
    input  logic        mul_z_stb,
    output logic        mul_out_busy,
    output logic        err_timeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RETURN = 2'd3;

    localparam logic [15:0] QNAN = 16'hFFC0;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] resp_data_q, resp_data_d;

    logic        req_any;
    logic [1:0]  pick;
    logic        timeout_hit;

    // Walk the ring backwards so the last hit is the first set bit at or after ptr.
    always_comb begin
        logic [1:0] idx;
        pick    = ptr_q;
        req_any = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req_stb[idx]) begin
                pick    = idx;
                req_any = 1'b1;
            end
        end
    end

`ifdef BF16_ARB_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_timeout_q, err_timeout_d;

    // Counter sits at zero outside WAIT, so it is already clear on entry.
    always_comb begin
        wait_cnt_d    = (state_q == S_WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
        timeout_hit   = (state_q == S_WAIT) && !mul_z_stb
                        && (wait_cnt_q + CNT_W'(1) == CNT_LIMIT);
        err_timeout_d = timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave one unassigned (no latches).
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        resp_data_d = resp_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    op_a_d  = req_a[{pick, 4'b0000} +: 16];
                    op_b_d  = req_b[{pick, 4'b0000} +: 16];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mul_busy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_z_stb) begin
                    resp_data_d = mul_z;
                    state_d     = S_RETURN;
                end else if (timeout_hit) begin
                    resp_data_d = QNAN;
                    state_d     = S_RETURN;
                end
            end
            S_RETURN: begin
                if (!resp_busy[grant_q]) begin
                    ptr_d   = grant_q + 2'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= 2'd0;
            grant_q     <= 2'd0;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            resp_data_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Every output below comes from state flops only; nothing combinational from the inputs.
    assign req_busy     = {4{state_q != S_IDLE}};
    assign mul_stb      = (state_q == S_ISSUE);
    assign mul_out_busy = (state_q == S_ISSUE) || (state_q == S_RETURN);
    assign resp_stb     = (state_q == S_RETURN) ? (4'b0001 << grant_q) : 4'b0000;
    assign resp_data    = resp_data_q;
    assign mul_a        = op_a_q;
    assign mul_b        = op_b_q;

    // The shared multiplier is reset together with the arbiter in the same cycle.
    assign mul_rst      = rst;

endmodule

// File: tb/tb_bf16_mult_arbiter.sv
// Self-checking bench for bf16_mult_arbiter: transaction-level model, bench-side multiplier and sinks.
// Define BF16_ARB_TIMEOUT_EN on both files to exercise the watchdog with TIMEOUT_CYCLES=8.
`timescale 1ns/1ps
module tb_bf16_mult_arbiter;

`ifdef BF16_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_stb, req_busy;
    logic [15:0] resp_data;
    logic [3:0]  resp_stb, resp_busy;
    logic [15:0] mul_a, mul_b, mul_z;
    logic        mul_stb, mul_busy, mul_rst, mul_z_stb, mul_out_busy, err_timeout;

    bf16_mult_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_busy(req_busy),
        .resp_data(resp_data), .resp_stb(resp_stb), .resp_busy(resp_busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_stb(mul_stb), .mul_busy(mul_busy),
        .mul_rst(mul_rst), .mul_z(mul_z), .mul_z_stb(mul_z_stb),
        .mul_out_busy(mul_out_busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction model: outstanding / issued / result-held flags plus round-robin pointer.
    bit          m_out, m_iss, m_cap, m_err;
    logic [1:0]  m_ptr, m_g;
    logic [15:0] m_a, m_b, m_data;
    int          m_wcnt;

    // Bench-side multiplier and requester/sink controls.
    bit          mz_pend, mz_mute, spur_en, rand_busy, rand_sink, rand_req, hold_stb;
    logic [15:0] mz_val;
    int          mz_wait, lat_max;
    bit   [3:0]  drop, r_pend, rb_force;
    int          err_pulses;

    logic        s_mul_out_busy;
    logic [15:0] s_mul_a, s_mul_b, s_resp_data;

    typedef struct { int g; logic [15:0] d; } comp_t;
    int    grant_log[$];
    comp_t comps[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Truncating bf16 multiply for normal operands/results.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [6:0]  f;
        int          e;
        p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            e++;
            f = p[14:8];
        end else begin
            f = p[13:7];
        end
        return {a[15] ^ b[15], 8'(e), f};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [3:0] stb);
        for (int k = 0; k < 4; k++) if (stb[(ptr + k) % 4]) return (ptr + k) % 4;
        return 0;
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] v;
        v[15]   = 1'($urandom);
        v[14:7] = 8'(8'h70 + $urandom_range(0, 31));
        v[6:0]  = 7'($urandom);
        return v;
    endfunction

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_stb[i]        = 1'b1;
    endtask

    // One clock: advance the model across the edge, compare outputs, drive the next inputs.
    task automatic step();
        int g;
        @(posedge clk);
        if (rst) begin
            m_out = 0; m_iss = 0; m_cap = 0; m_err = 0; m_ptr = 2'd0;
            mz_pend = 0; r_pend = '0; drop = '0;
        end else begin
            m_err = 0;
            if (mul_z_stb && !s_mul_out_busy) mz_pend = 0;
            if (!m_out) begin
                if (req_stb != 4'b0000) begin
                    g      = rr_pick(int'(m_ptr), req_stb);
                    m_g    = 2'(g);
                    m_a    = req_a[16*g +: 16];
                    m_b    = req_b[16*g +: 16];
                    m_data = bf16_mul(m_a, m_b);
                    m_out  = 1;
                    grant_log.push_back(g);
                    if (!hold_stb) drop[g] = 1'b1;
                end
            end else if (!m_iss) begin
                if (!mul_busy) begin
                    m_iss   = 1;
                    m_wcnt  = 0;
                    mz_pend = 1;
                    mz_val  = bf16_mul(s_mul_a, s_mul_b);
                    mz_wait = $urandom_range(0, lat_max);
                end
            end else if (!m_cap) begin
                if (mul_z_stb) begin
                    m_cap = 1;
                end else begin
                    m_wcnt++;
`ifdef BF16_ARB_TIMEOUT_EN
                    if (m_wcnt == TMO) begin
                        m_cap  = 1;
                        m_data = 16'hFFC0;
                        m_err  = 1;
                    end
`endif
                end
            end else if (!resp_busy[m_g]) begin
                comps.push_back('{int'(m_g), s_resp_data});
                r_pend[m_g] = 1'b0;
                m_ptr = m_g + 2'd1;
                m_out = 0; m_iss = 0; m_cap = 0;
            end
        end

        #1;
        s_mul_out_busy = mul_out_busy;
        s_mul_a        = mul_a;
        s_mul_b        = mul_b;
        s_resp_data    = resp_data;
        check("req_busy", req_busy, m_out ? 4'hF : 4'h0);
        check("mul_stb", mul_stb, m_out && !m_iss);
        check("mul_out_busy", mul_out_busy, m_out && (!m_iss || m_cap));
        check("resp_stb", resp_stb, m_cap ? 4'(1 << m_g) : 4'h0);
        check("err_timeout", err_timeout, m_err);
        check("mul_rst", mul_rst, rst);
        if (m_cap) check("resp_data", resp_data, m_data);
        if (m_out && !m_iss) begin
            check("mul_a", mul_a, m_a);
            check("mul_b", mul_b, m_b);
        end
        if (err_timeout) err_pulses++;

        req_stb = req_stb & ~drop;
        drop    = '0;
        if (rand_req) begin
            for (int i = 0; i < 4; i++) begin
                if (!r_pend[i] && !req_stb[i] && $urandom_range(0, 5) == 0) begin
                    set_req(i, rand_bf16(), rand_bf16());
                    r_pend[i] = 1'b1;
                end
            end
        end
        if (mz_pend && !mz_mute) begin
            if (mz_wait > 0) begin
                mz_wait--;
                mul_z_stb = 1'b0;
            end else begin
                mul_z_stb = 1'b1;
                mul_z     = mz_val;
            end
        end else if (spur_en && !m_out && !mz_pend && $urandom_range(0, 3) == 0) begin
            mul_z_stb = 1'b1;
            mul_z     = 16'($urandom);
        end else begin
            mul_z_stb = 1'b0;
        end
        mul_busy  = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
        resp_busy = rb_force | (rand_sink ? 4'($urandom) : 4'h0);
    endtask

    task automatic run_until_idle(input string name, input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((m_out || req_stb != 4'b0000) && n < max);
        check({name, "_finished"}, (m_out || req_stb != 4'b0000) ? 1'b0 : 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        req_stb = 4'b0000;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        grant_log.delete();
        comps.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; req_a = '0; req_b = '0; req_stb = '0; resp_busy = '0;
        mul_busy = 1'b0; mul_z = '0; mul_z_stb = 1'b0;
        mz_mute = 0; spur_en = 0; rand_busy = 0; rand_sink = 0; rand_req = 0; hold_stb = 0;
        lat_max = 0; rb_force = '0; err_pulses = 0; drop = '0; r_pend = '0;
        s_mul_out_busy = 1'b0; s_mul_a = '0; s_mul_b = '0; s_resp_data = '0;

        repeat (3) step();
        check("rst_resp_data", resp_data, 16'h0000);
        check("rst_req_busy", req_busy, 4'h0);
        check("rst_resp_stb", resp_stb, 4'h0);
        rst = 1'b0;

        // Single requester 0: 1.5 x 2.0 = 3.0
        set_req(0, 16'h3FC0, 16'h4000);
        run_until_idle("t_single", 50);
        check("t_single_count", comps.size(), 1);
        if (comps.size() >= 1) begin
            check("t_single_grant", comps[0].g, 0);
            check("t_single_data", comps[0].d, 16'h4040);
        end
        // ptr now 1: requester 1 wins over requester 0
        grant_log.delete(); comps.delete();
        set_req(0, 16'h3FC0, 16'h4000);
        set_req(1, 16'h3F80, 16'h4000);
        run_until_idle("t_ptr", 80);
        check("t_ptr_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("t_ptr_first", grant_log[0], 1);
            check("t_ptr_second", grant_log[1], 0);
            check("t_ptr_data", comps[0].d, 16'h4000);
        end

        // After reset, requesters 0 and 2 together: 0 first, then 2 with 1.0 x -2.0
        do_reset();
        set_req(0, 16'h3FC0, 16'h3F80);
        set_req(2, 16'h3F80, 16'hC000);
        run_until_idle("t_pair", 80);
        check("t_pair_count", comps.size(), 2);
        if (comps.size() >= 2) begin
            check("t_pair_first", comps[0].g, 0);
            check("t_pair_second", comps[1].g, 2);
            check("t_pair_data", comps[1].d, 16'hC000);
        end

        // All four held continuously from ptr=0
        do_reset();
        hold_stb = 1;
        for (int i = 0; i < 4; i++) set_req(i, rand_bf16(), rand_bf16());
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            step();
            n++;
        end
        hold_stb = 0;
        req_stb  = 4'b0000;
        run_until_idle("t_all4", 50);
        check("t_all4_count", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("t_all4_order%0d", i), grant_log[i], i % 4);
        end

        // Sink 1 busy for 10 cycles in RETURN while requester 0 waits
        grant_log.delete(); comps.delete();
        rb_force = 4'b0010;
        set_req(1, 16'h3FC0, 16'h3FC0);
        n = 0;
        while (!m_cap && n < 50) begin
            step();
            n++;
        end
        check("t_stall_reached", m_cap, 1'b1);
        set_req(0, 16'h3F80, 16'h3F80);
        repeat (10) step();
        check("t_stall_stb", resp_stb, 4'b0010);
        check("t_stall_data", resp_data, 16'h4010);
        check("t_stall_grants", grant_log.size(), 1);
        rb_force = 4'b0000;
        run_until_idle("t_stall", 50);
        check("t_stall_count", comps.size(), 2);
        if (comps.size() >= 2) begin
            check("t_stall_g1", comps[0].g, 1);
            check("t_stall_g0", comps[1].g, 0);
        end

        // Reset while in WAIT abandons the transaction
        grant_log.delete(); comps.delete();
        mz_mute = 1;
        set_req(3, 16'h4000, 16'h4000);
        n = 0;
        while (!m_iss && n < 50) begin
            step();
            n++;
        end
        repeat (3) step();
        check("t_rst_in_wait", mul_out_busy, 1'b0);
        rst = 1'b1;
        step();
        check("t_rst_req_busy", req_busy, 4'h0);
        check("t_rst_mul_stb", mul_stb, 1'b0);
        check("t_rst_resp_stb", resp_stb, 4'h0);
        check("t_rst_resp_data", resp_data, 16'h0000);
        rst = 1'b0;
        mz_mute = 0;
        set_req(2, 16'h3F80, 16'h3F80);
        run_until_idle("t_rst", 50);
        check("t_rst_count", comps.size(), 1);
        if (comps.size() >= 1) begin
            check("t_rst_grant", comps[0].g, 2);
            check("t_rst_data", comps[0].d, 16'h3F80);
        end

`ifdef BF16_ARB_TIMEOUT_EN
        // Watchdog: no result -> qNaN, one err pulse; the late result is dropped in IDLE
        grant_log.delete(); comps.delete();
        err_pulses = 0;
        mz_mute = 1;
        set_req(0, 16'h3F80, 16'h3F80);
        run_until_idle("t_tmo", 60);
        check("t_tmo_pulses", err_pulses, 1);
        if (comps.size() >= 1) check("t_tmo_data", comps[0].d, 16'hFFC0);
        mz_mute = 0;
        repeat (3) step();
        set_req(1, 16'h3FC0, 16'h4000);
        run_until_idle("t_tmo_after", 50);
        check("t_tmo_count", comps.size(), 2);
        if (comps.size() >= 2) check("t_tmo_after_data", comps[1].d, 16'h4040);
`endif

        // Randomised traffic, back-pressure everywhere, stray results in IDLE
        grant_log.delete(); comps.delete();
        rand_req = 1; rand_busy = 1; rand_sink = 1; spur_en = 1; lat_max = 3;
        repeat (2000) step();
        rand_req = 0;
        run_until_idle("t_rand", 500);
        check("t_rand_volume", comps.size() > 50, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "bench time limit reached");
    end

endmodule
